video_regs: RTL

VIDEO_REGS -- requirements
Module: video_regs

---
 rtl/video_pkg.sv | 38 +++
 rtl/video_regs.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the video colour/raster register block:
//   - colour and compare widths, vblank boundary row
//   - register offsets within the 8-byte window
//   - bus access FSM state encoding
//   - helper that presents one byte of a committed colour for reads
package video_pkg;

    localparam int unsigned COLOR_W    = 12;
    localparam int unsigned CMP_W      = 9;
    localparam logic [8:0]  VBLANK_ROW = 9'd480;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        REG_FG_LO  = 3'd0,
        REG_FG_HI  = 3'd1,
        REG_BG_LO  = 3'd2,
        REG_BG_HI  = 3'd3,
        REG_CMP_LO = 3'd4,
        REG_CMP_HI = 3'd5,
        REG_STATUS = 3'd6,
        REG_CTRL   = 3'd7
    } reg_off_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_RESP    = 2'd2,
        ST_WAITLOW = 2'd3
    } bus_state_e;

    // Low byte, or the 4 used high bits zero-extended.
    function automatic logic [7:0] color_byte(input color_t c, input logic hi);
        return hi ? {4'b0000, c[11:8]} : c[7:0];
    endfunction

endpackage

// File: rtl/video_regs.sv
// video_regs
// Bus-accessible colour and raster-interrupt registers, clocked by the
// pixel clock. Colours are written as LO (staged) then HI (commits both
// halves at once). A compare line raises a sticky raster-hit flag that can
// drive a level interrupt.
//
// Ports:
//   i_clk, i_rstn          pixel clock, async active-low reset
//   i_stb, i_we            level strobe (rising edge starts access), write
//   i_addr, i_data         byte address, write data
//   o_data, o_data_ready   read data (zero unless ready), 1-cycle done pulse
//   i_scan_row/column      current raster position
//   o_fg_color, o_bg_color committed colours
//   o_irq                  STATUS[0] & CTRL[0]
module video_regs
    import video_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h80,
    parameter color_t     RESET_FG  = 12'hFFF,
    parameter color_t     RESET_BG  = 12'h000
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_stb,
    input  logic               i_we,
    input  logic [7:0]         i_addr,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    output logic               o_data_ready,
    input  logic [8:0]         i_scan_row,
    input  logic [9:0]         i_scan_column,
    output logic [COLOR_W-1:0] o_fg_color,
    output logic [COLOR_W-1:0] o_bg_color,
    output logic               o_irq
);

    bus_state_e         r_state;
    bus_state_e         w_next_state;

    logic               r_stb_q;
    logic               r_seen_low;
    logic               w_stb_edge;
    logic               w_addr_hit;
    logic               w_start;
    logic               w_exec;

    logic               r_we;
    reg_off_e           r_off;
    logic [7:0]         r_wdata;

    color_t             r_fg;
    color_t             r_bg;
    logic [7:0]         r_fg_shadow;
    logic [7:0]         r_bg_shadow;
    logic [CMP_W-1:0]   r_cmp;
    logic               r_hit;
    logic               r_irq_en;

    logic [7:0]         r_rdata;
    logic               r_ready;

    logic               w_wr;
    logic               w_w1c;
    logic               w_raster_hit;
    logic               w_vblank;
    logic [7:0]         w_rd_mux;

    // Strobe edge detection. r_seen_low stays clear until i_stb has been
    // observed low after reset, so a strobe held high across reset release
    // is not mistaken for a fresh edge.
    assign w_stb_edge = i_stb & ~r_stb_q & r_seen_low;
    assign w_addr_hit = (i_addr[7:3] == BASE_ADDR[7:3]);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stb_q    <= 1'b0;
            r_seen_low <= 1'b0;
        end else begin
            r_stb_q <= i_stb;
            if (!i_stb) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and control strobes. Missed addresses never leave IDLE,
    // so they cause no state change and no ready pulse.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_stb_edge && w_addr_hit) begin
                    w_start      = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec       = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_next_state = i_stb ? ST_WAITLOW : ST_IDLE;
            end
            ST_WAITLOW: begin
                if (!i_stb) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture in the edge cycle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_we    <= 1'b0;
            r_off   <= REG_FG_LO;
            r_wdata <= '0;
        end else if (w_start) begin
            r_we    <= i_we;
            r_off   <= reg_off_e'(i_addr[2:0]);
            r_wdata <= i_data;
        end
    end

    assign w_wr  = w_exec & r_we;
    assign w_w1c = w_wr & (r_off == REG_STATUS) & r_wdata[0];

    // Colour, compare and control registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fg        <= RESET_FG;
            r_bg        <= RESET_BG;
            r_fg_shadow <= '0;
            r_bg_shadow <= '0;
            r_cmp       <= '0;
            r_irq_en    <= 1'b0;
        end else if (w_wr) begin
            case (r_off)
                REG_FG_LO:  r_fg_shadow <= r_wdata;
                REG_FG_HI:  r_fg        <= {r_wdata[3:0], r_fg_shadow};
                REG_BG_LO:  r_bg_shadow <= r_wdata;
                REG_BG_HI:  r_bg        <= {r_wdata[3:0], r_bg_shadow};
                REG_CMP_LO: r_cmp       <= {r_cmp[8], r_wdata};
                REG_CMP_HI: r_cmp       <= {r_wdata[0], r_cmp[7:0]};
                REG_CTRL:   r_irq_en    <= r_wdata[0];
                default: ;
            endcase
        end
    end

    // Raster-hit flag: a hit in the same cycle as a W1C keeps the flag set.
    assign w_raster_hit = (i_scan_row == r_cmp) && (i_scan_column == '0);
    assign w_vblank     = (i_scan_row >= VBLANK_ROW);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_raster_hit | (r_hit & ~w_w1c);
        end
    end

    // Read mux: committed colours only, never the shadows
    always_comb begin
        w_rd_mux = '0;
        case (r_off)
            REG_FG_LO:  w_rd_mux = color_byte(r_fg, 1'b0);
            REG_FG_HI:  w_rd_mux = color_byte(r_fg, 1'b1);
            REG_BG_LO:  w_rd_mux = color_byte(r_bg, 1'b0);
            REG_BG_HI:  w_rd_mux = color_byte(r_bg, 1'b1);
            REG_CMP_LO: w_rd_mux = r_cmp[7:0];
            REG_CMP_HI: w_rd_mux = {7'b0, r_cmp[8]};
            REG_STATUS: w_rd_mux = {6'b0, w_vblank, r_hit};
            REG_CTRL:   w_rd_mux = {7'b0, r_irq_en};
            default:    w_rd_mux = '0;
        endcase
    end

    // Response registers: loaded in EXEC, so they are valid during RESP
    // and forced back to zero on every other cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_exec;
            r_rdata <= (w_exec && !r_we) ? w_rd_mux : '0;
        end
    end

    assign o_data       = r_rdata;
    assign o_data_ready = r_ready;
    assign o_fg_color   = r_fg;
    assign o_bg_color   = r_bg;
    assign o_irq        = r_hit & r_irq_en;

endmodule
